// File: rtl/mem_uart_ctrl_if.sv
// CPU-side request/response bus of the SRAM + UART controller.
interface mem_uart_ctrl_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 18
);
    logic              req;
    logic              rd;
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              done;
    logic              err;
    logic [DATA_W-1:0] rdata;

    modport master (output req, rd, wr, addr, wdata, input done, err, rdata);
    modport slave  (input req, rd, wr, addr, wdata, output done, err, rdata);
endinterface

// File: rtl/mem_uart_ctrl.sv
// SRAM + UART bus controller: serves one CPU access at a time on the shared
// Ram1 bus and drains UART receive bytes into a small RX FIFO in between.
module mem_uart_ctrl #(
    parameter int              DATA_W     = 16,
    parameter int              ADDR_W     = 18,
    parameter int              FIFO_AW    = 4,
    parameter int              WAIT_CYC   = 2,
    parameter logic [ADDR_W-1:0] UART_DADDR = ADDR_W'('h0BF00),
    parameter logic [ADDR_W-1:0] UART_SADDR = ADDR_W'('h0BF01)
) (
    input  logic               clk,
    input  logic               rst,
    mem_uart_ctrl_if.slave     cpu,
    output logic [ADDR_W-1:0]  ram_addr,
    inout  wire  [DATA_W-1:0]  ram_data,
    output logic               ram_en,
    output logic               ram_oe,
    output logic               ram_we,
    output logic               rdn,
    output logic               wrn,
    input  logic               data_ready,
    input  logic               tbre,
    input  logic               tsre,
    output logic [FIFO_AW:0]   rx_count,
    output logic               rx_ovf
);
    localparam int DEPTH = 2 ** FIFO_AW;
    localparam int CNT_W = (WAIT_CYC > 1) ? $clog2(WAIT_CYC) : 1;

    typedef enum logic [3:0] {
        S_IDLE, S_RX1, S_RX2, S_TX1, S_TX2, S_TX3, S_TX4,
        S_RRD, S_RWR, S_RWT, S_QPOP, S_STAT, S_DONE
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic [DATA_W-1:0]    wdata_q, wdata_d;
    logic [DATA_W-1:0]    rdata_q, rdata_d;
    logic [7:0]           rx_byte_q, rx_byte_d;
    logic [FIFO_AW-1:0]   head_q, head_d, tail_q, tail_d;
    logic [FIFO_AW:0]     count_q, count_d;
    logic                 ovf_q, ovf_d;
    logic                 err_q, err_d;
    logic                 hold_q, hold_d;
    logic                 fifo_we;
    logic                 full, empty;
    logic                 drive;
    logic [DATA_W-1:0]    bus_out;
    logic [7:0]           fifo_mem [DEPTH];

    assign full  = (count_q == (FIFO_AW+1)'(DEPTH));
    assign empty = (count_q == '0);

    // State and datapath registers; async reset also releases the bus at once
    // because every strobe and the drive enable are decoded from state_q.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            rx_byte_q <= '0;
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
            ovf_q     <= 1'b0;
            err_q     <= 1'b0;
            hold_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            rx_byte_q <= rx_byte_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
            ovf_q     <= ovf_d;
            err_q     <= err_d;
            hold_q    <= hold_d;
        end
    end

    // RX FIFO storage; contents are don't-care after reset since pointers clear.
    always_ff @(posedge clk) begin
        if (fifo_we) fifo_mem[tail_q] <= rx_byte_q;
    end

    // Next-state: arbitration in IDLE, then one access sequence per request.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        rx_byte_d = rx_byte_q;
        head_d    = head_q;
        tail_d    = tail_q;
        count_d   = count_q;
        ovf_d     = ovf_q;
        err_d     = err_q;
        hold_d    = hold_q;
        fifo_we   = 1'b0;
        case (state_q)
            S_IDLE: begin
                // A request that was just served must drop before it counts again.
                if (!cpu.req) hold_d = 1'b0;
                if (data_ready && !full) begin
                    state_d = S_RX1;
                end else if (cpu.req && !hold_q) begin
                    addr_d  = cpu.addr;
                    wdata_d = cpu.wdata;
                    err_d   = 1'b0;
                    cnt_d   = '0;
                    hold_d  = 1'b1;
                    if (cpu.rd == cpu.wr) begin
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end else if (cpu.addr == UART_DADDR) begin
                        state_d = cpu.wr ? S_TX1 : S_QPOP;
                    end else if (cpu.addr == UART_SADDR) begin
                        if (cpu.wr) begin
                            err_d   = 1'b1;
                            state_d = S_DONE;
                        end else begin
                            state_d = S_STAT;
                        end
                    end else begin
                        state_d = cpu.wr ? S_RWR : S_RRD;
                    end
                end else if (data_ready) begin
                    // FIFO full and nothing else to do: read the byte to drop it.
                    state_d = S_RX1;
                end
            end
            S_RX1: begin
                // Sample while rdn is still low so the UART is certainly driving.
                rx_byte_d = ram_data[7:0];
                state_d   = S_RX2;
            end
            S_RX2: begin
                if (!full) begin
                    fifo_we = 1'b1;
                    tail_d  = tail_q + 1'b1;
                    count_d = count_q + 1'b1;
                end else begin
                    ovf_d = 1'b1;
                end
                state_d = S_IDLE;
            end
            S_TX1: state_d = S_TX2;
            S_TX2: state_d = S_TX3;
            S_TX3: if (tbre) state_d = S_TX4;
            S_TX4: if (tsre) state_d = S_DONE;
            S_RRD: begin
                if (cnt_q == CNT_W'(WAIT_CYC - 1)) begin
                    rdata_d = ram_data;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_RWR: begin
                if (cnt_q == CNT_W'(WAIT_CYC - 1)) state_d = S_RWT;
                else                                 cnt_d   = cnt_q + 1'b1;
            end
            S_RWT: state_d = S_DONE;
            S_QPOP: begin
                if (!empty) begin
                    rdata_d = DATA_W'(fifo_mem[head_q]);
                    head_d  = head_q + 1'b1;
                    count_d = count_q - 1'b1;
                end else begin
                    rdata_d = '0;
                end
                state_d = S_DONE;
            end
            S_STAT: begin
                rdata_d = DATA_W'({ovf_q, !empty, tbre & tsre});
                ovf_d   = 1'b0;
                state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Pin decode: active-low strobes and bus drive follow the current state only.
    always_comb begin
        ram_en  = 1'b1;
        ram_oe  = 1'b1;
        ram_we  = 1'b1;
        rdn     = 1'b1;
        wrn     = 1'b1;
        drive   = 1'b0;
        bus_out = wdata_q;
        case (state_q)
            S_RX1: rdn = 1'b0;
            S_TX1: begin
                wrn     = 1'b0;
                drive   = 1'b1;
                bus_out = {{(DATA_W-8){1'b0}}, wdata_q[7:0]};
            end
            S_TX2: begin
                drive   = 1'b1;
                bus_out = {{(DATA_W-8){1'b0}}, wdata_q[7:0]};
            end
            S_RRD: begin
                ram_en = 1'b0;
                ram_oe = 1'b0;
            end
            S_RWR: begin
                ram_en = 1'b0;
                ram_we = 1'b0;
                drive  = 1'b1;
            end
            S_RWT: begin
                ram_en = 1'b0;
                drive  = 1'b1;
            end
            default: ;
        endcase
    end

    assign ram_data  = drive ? bus_out : {DATA_W{1'bz}};
    assign ram_addr  = addr_q;
    assign rx_count  = count_q;
    assign rx_ovf    = ovf_q;
    assign cpu.done  = (state_q == S_DONE);
    assign cpu.err   = (state_q == S_DONE) && err_q;
    assign cpu.rdata = rdata_q;
endmodule
